pedestrian_request_unit: RTL and testbench
==========================================

# pedestrian_request_unit

- Front end for the pedestrian crossings of the traffic signal controller.
- Synchronizes and debounces eight raw push-buttons, then latches each press as a held request.
- Drives the request to the controller's pedestrian inputs and holds it until the controller's matching walk output has been granted and released.
- Reports service completion, overdue waits and protocol errors.

## Interface
- NUM_XING, 8, number of crossings. Bit order: 0 north, 1 south, 2 east, 3 west, 4 north_one, 5 south_one, 6 east_one, 7 west_one.
- DEBOUNCE_CYCLES, 4, number of extra consecutive synchronized-high samples required after the first (range 1..15).
- COOLDOWN_CYCLES, 8, number of cycles after service during which the button is ignored (range 1..255).
- WAIT_LIMIT, 200, count of pending cycles at which a request becomes overdue (range 1..255).

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- button_raw  in  NUM_XING  asynchronous raw buttons, 1 = pressed.
- walk_grant  in  NUM_XING  controller pedestrian walk outputs, same bit order.
- request_out  out  NUM_XING  held request to the controller pedestrian inputs.
- walk_served  out  NUM_XING  one-cycle pulse when a grant ends.
- overdue  out  NUM_XING  level, wait count has reached WAIT_LIMIT.
- grant_error  out  NUM_XING  sticky, grant seen while no request was held.
- pending_count  out  4  number of channels in PENDING or SERVING.

## Operation
- Each button passes through a 2-flop synchronizer, giving btn_s. Each channel then runs its own FSM with states IDLE, DEBOUNCE, PENDING, SERVING, COOLDOWN.
- IDLE: if btn_s=1, go to DEBOUNCE with cnt=1.
- DEBOUNCE:
  - btn_s=0: go to IDLE.
  - cnt==DEBOUNCE_CYCLES: go to PENDING with wait=0.
  - otherwise: cnt+1.
- PENDING:
  - wait increments and saturates at 255.
  - walk_grant=1: go to SERVING.
  - btn_s is ignored.
- SERVING:
  - Stay while walk_grant=1.
  - On walk_grant=0: go to COOLDOWN with cnt=0, and pulse walk_served for one cycle.
- COOLDOWN:
  - cnt+1 until cnt==COOLDOWN_CYCLES-1.
  - Then go to IDLE only if btn_s=0. Otherwise hold in COOLDOWN until release, so a stuck button never re-requests.
- request_out = (state==PENDING or SERVING); it is decoded from registered state and has no glitches.
- overdue = (state==PENDING and wait>=WAIT_LIMIT). It clears on leaving PENDING.
- grant_error bit sets when walk_grant=1 in IDLE, DEBOUNCE or COOLDOWN. It clears only on reset.
- pending_count is registered and is the popcount of channels with request_out=1 as of the previous cycle.
- Channels are fully independent. Simultaneous presses on all eight channels are legal, giving pending_count=8.
- Counters are 8-bit unsigned. No arithmetic wraps: wait saturates, and cnt is bounded by the parameters.

## Timing
- Reset values (asynchronous):
  - All FSMs in IDLE, all counters 0, synchronizer flops 0.
  - request_out=0, walk_served=0, overdue=0, grant_error=0, pending_count=0.
- Press latency: button_raw stable high before edge 0 gives request_out high after edge DEBOUNCE_CYCLES+2 (edge 6 at default).
- A press is rejected if btn_s stays high for fewer than DEBOUNCE_CYCLES+1 consecutive samples.
- Grant to state: walk_grant high before edge n puts the FSM in SERVING after edge n. request_out stays 1 throughout.
- Release: walk_grant low before edge m gives walk_served=1 for the cycle after edge m and request_out=0 from edge m.
- overdue rises after the edge at which wait reaches WAIT_LIMIT.
- Grant and release of the same channel in consecutive cycles is legal. SERVING then lasts one cycle.
- Reset asserted mid-operation drops all outputs immediately. No walk_served pulse is emitted.

## Structure
- Package ped_pkg holds:
  - the channel index constants (XING_NORTH … XING_WEST_ONE);
  - the ped_state_t enum with its 3-bit encoding;
  - the NUM_XING default.
- Sub-module ped_channel_fsm holds one synchronizer, the FSM and the counters for a single crossing.
- The top level instantiates NUM_XING copies via generate and adds the registered popcount.

## Test plan
- Clean press, default parameters: ch2 high from edge 0 → request_out[2]=1 after edge 6, pending_count=1 after edge 7.
- Glitch: ch0 high for 3 cycles → request_out stays 0 and the FSM returns to IDLE.
- Full handshake on ch3:
  - Pend, then walk_grant[3]=1 for 10 cycles → request_out[3] holds 1 throughout.
  - Grant falls → walk_served[3] pulses once and request_out[3]=0.
- Stuck button: ch4 held through service and 20 more cycles → no second request until release.
  - After release and re-press, request_out rises again DEBOUNCE_CYCLES+2 cycles later.
- Overdue and error:
  - ch1 pending with no grant for 200 cycles → overdue[1]=1. A grant then clears it.
  - walk_grant[5]=1 with ch5 IDLE → grant_error[5]=1, which persists until reset.
- All eight channels pressed together, then reset_n pulsed low mid-PENDING → every output is 0 immediately and pending_count goes from 8 to 0.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian request front end.
//   - Crossing index constants, in bit order of every NUM_XING-wide port.
//   - ped_state_t: per-channel FSM state, 3-bit encoding.
//   - NUM_XING_DEFAULT: default number of crossings.
package ped_pkg;

  localparam int unsigned NUM_XING_DEFAULT = 8;

  localparam int unsigned XING_NORTH     = 0;
  localparam int unsigned XING_SOUTH     = 1;
  localparam int unsigned XING_EAST      = 2;
  localparam int unsigned XING_WEST      = 3;
  localparam int unsigned XING_NORTH_ONE = 4;
  localparam int unsigned XING_SOUTH_ONE = 5;
  localparam int unsigned XING_EAST_ONE  = 6;
  localparam int unsigned XING_WEST_ONE  = 7;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDebounce = 3'd1,
    StPending  = 3'd2,
    StServing  = 3'd3,
    StCooldown = 3'd4
  } ped_state_t;

endpackage

// File: rtl/ped_channel_fsm.sv
// One pedestrian crossing: 2-flop button synchronizer, debounce, held request,
// grant/release handshake and post-service cooldown.
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset
//   button_raw      : asynchronous raw button, 1 = pressed
//   walk_grant      : controller walk output for this crossing
//   request_out     : held request (PENDING or SERVING), decoded from state
//   walk_served     : one-cycle pulse after the grant ends
//   overdue         : pending wait has reached WAIT_LIMIT
//   grant_error     : sticky, grant seen while no request was held
module ped_channel_fsm
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COOLDOWN_CYCLES = 8,
  parameter int unsigned WAIT_LIMIT      = 200
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button_raw,
  input  logic walk_grant,
  output logic request_out,
  output logic walk_served,
  output logic overdue,
  output logic grant_error
);

  localparam logic [7:0] DebLast  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] CoolLast = 8'(COOLDOWN_CYCLES - 1);
  localparam logic [7:0] WaitLim  = 8'(WAIT_LIMIT);

  logic       sync_q, btn_s;
  ped_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] wait_q, wait_d;
  logic       served_q, served_d;
  logic       err_q, err_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 1'b0;
      btn_s    <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      wait_q   <= 8'd0;
      served_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_q   <= button_raw;
      btn_s    <= sync_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      served_q <= served_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    served_d = 1'b0;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StDebounce;
          cnt_d   = 8'd1;
        end
      end
      StDebounce: begin
        if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (cnt_q == DebLast) begin
          state_d = StPending;
          cnt_d   = 8'd0;
          wait_d  = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StPending: begin
        if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
        if (walk_grant) state_d = StServing;
      end
      StServing: begin
        if (!walk_grant) begin
          state_d  = StCooldown;
          cnt_d    = 8'd0;
          served_d = 1'b1;
        end
      end
      StCooldown: begin
        // A held button keeps the channel here so it cannot re-request.
        if (cnt_q != CoolLast) begin
          cnt_d = cnt_q + 8'd1;
        end else if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase

    if (walk_grant && (state_q inside {StIdle, StDebounce, StCooldown})) err_d = 1'b1;
  end

  assign request_out = (state_q == StPending) || (state_q == StServing);
  assign overdue     = (state_q == StPending) && (wait_q >= WaitLim);
  assign walk_served = served_q;
  assign grant_error = err_q;

endmodule

// File: rtl/pedestrian_request_unit.sv
// Pedestrian crossing front end: NUM_XING independent button channels plus a
// registered count of outstanding requests.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   button_raw     : raw push-buttons, 1 = pressed
//   walk_grant     : controller walk outputs
//   request_out    : held requests to the controller
//   walk_served    : one-cycle pulse per channel when its grant ends
//   overdue        : per-channel wait reached WAIT_LIMIT
//   grant_error    : sticky per-channel unexpected-grant flag
//   pending_count  : popcount of request_out as of the previous cycle
module pedestrian_request_unit
  import ped_pkg::*;
#(
  parameter int unsigned NUM_XING        = NUM_XING_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COOLDOWN_CYCLES = 8,
  parameter int unsigned WAIT_LIMIT      = 200
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_XING-1:0] button_raw,
  input  logic [NUM_XING-1:0] walk_grant,
  output logic [NUM_XING-1:0] request_out,
  output logic [NUM_XING-1:0] walk_served,
  output logic [NUM_XING-1:0] overdue,
  output logic [NUM_XING-1:0] grant_error,
  output logic [3:0]          pending_count
);

  for (genvar i = 0; i < NUM_XING; i++) begin : g_xing
    ped_channel_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
      .WAIT_LIMIT     (WAIT_LIMIT)
    ) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .button_raw (button_raw[i]),
      .walk_grant (walk_grant[i]),
      .request_out(request_out[i]),
      .walk_served(walk_served[i]),
      .overdue    (overdue[i]),
      .grant_error(grant_error[i])
    );
  end

  logic [3:0] count_d, count_q;

  always_comb begin
    count_d = 4'd0;
    for (int i = 0; i < NUM_XING; i++) count_d = count_d + 4'(request_out[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= 4'd0;
    else          count_q <= count_d;
  end

  assign pending_count = count_q;

endmodule

// File: tb/tb_pedestrian_request_unit.sv
// Scoreboard bench: a reference model pushes expected outputs at each rising
// edge; a monitor pops and compares them on the falling edge.
module tb_pedestrian_request_unit;
  import ped_pkg::*;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int CD = 8;
  localparam int WL = 200;

  logic         clock;
  logic         reset_n;
  logic [N-1:0] button_raw, walk_grant;
  logic [N-1:0] request_out, walk_served, overdue, grant_error;
  logic [3:0]   pending_count;

  pedestrian_request_unit #(
    .NUM_XING       (N),
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_CYCLES(CD),
    .WAIT_LIMIT     (WL)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .button_raw   (button_raw),
    .walk_grant   (walk_grant),
    .request_out  (request_out),
    .walk_served  (walk_served),
    .overdue      (overdue),
    .grant_error  (grant_error),
    .pending_count(pending_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] req;
    logic [7:0] served;
    logic [7:0] ovd;
    logic [7:0] err;
    logic [3:0] pc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: channel phases tracked as plain counters of samples/cycles.
  localparam int MFree = 0, MWaiting = 1, MWalking = 2, MResting = 3;
  int           m_mode[N], m_run[N], m_waited[N], m_rested[N];
  logic [N-1:0] m_err, m_req, h1, h2;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = MFree; m_run[i] = 0; m_waited[i] = 0; m_rested[i] = 0;
    end
    m_err = '0; m_req = '0; h1 = '0; h2 = '0;
  endtask

  task automatic model_step();
    exp_t         e;
    logic [N-1:0] s;
    e = '0;
    if (!reset_n) begin
      model_reset();
    end else begin
      // Button seen by a channel at this edge was sampled two edges earlier.
      s  = h2;
      h2 = h1;
      h1 = button_raw;
      e.pc = 4'($countones(m_req));
      for (int i = 0; i < N; i++) begin
        case (m_mode[i])
          MFree: begin
            if (walk_grant[i]) m_err[i] = 1'b1;
            m_run[i] = s[i] ? m_run[i] + 1 : 0;
            if (m_run[i] == DB + 1) begin
              m_mode[i] = MWaiting; m_waited[i] = 0; m_run[i] = 0;
            end
          end
          MWaiting: begin
            if (m_waited[i] < 255) m_waited[i]++;
            if (walk_grant[i]) m_mode[i] = MWalking;
          end
          MWalking: begin
            if (!walk_grant[i]) begin
              m_mode[i] = MResting; m_rested[i] = 0; e.served[i] = 1'b1;
            end
          end
          default: begin
            if (walk_grant[i]) m_err[i] = 1'b1;
            if (m_rested[i] >= CD - 1 && !s[i]) begin
              m_mode[i] = MFree; m_run[i] = 0;
            end else begin
              m_rested[i]++;
            end
          end
        endcase
      end
      for (int i = 0; i < N; i++) begin
        m_req[i]  = (m_mode[i] == MWaiting) || (m_mode[i] == MWalking);
        e.ovd[i]  = (m_mode[i] == MWaiting) && (m_waited[i] >= WL);
      end
      e.req = m_req;
      e.err = m_err;
    end
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  initial begin : monitor_proc
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("sb_request_out", request_out, e.req);
        cmp("sb_walk_served", walk_served, e.served);
        cmp("sb_overdue", overdue, e.ovd);
        cmp("sb_grant_error", grant_error, e.err);
        cmp("sb_pending_count", {4'd0, pending_count}, {4'd0, e.pc});
      end
    end
  end

  // Inputs change 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  int g_hold[N];
  int pulses;

  initial begin : stim
    reset_n    = 1'b0;
    button_raw = '0;
    walk_grant = '0;
    tick(3);
    cmp("reset_request_out", request_out, 8'h00);
    cmp("reset_pending_count", {4'd0, pending_count}, 8'h00);

    // Clean press on east: request after edge DB+2, count one edge later.
    reset_n = 1'b1;
    button_raw[XING_EAST] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick(1);
      cmp("press_latency_req", {7'd0, request_out[XING_EAST]}, 8'(e >= DB + 2));
      cmp("press_latency_count", {4'd0, pending_count}, 8'(e >= DB + 3));
    end
    button_raw[XING_EAST] = 1'b0;

    // Three-cycle glitch on north is rejected.
    button_raw[XING_NORTH] = 1'b1;
    tick(3);
    button_raw[XING_NORTH] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick(1);
      cmp("glitch_req", {7'd0, request_out[XING_NORTH]}, 8'h00);
    end

    // Full handshake on west.
    button_raw[XING_WEST] = 1'b1;
    tick(DB + 3);
    button_raw[XING_WEST] = 1'b0;
    cmp("hs_pending", {7'd0, request_out[XING_WEST]}, 8'h01);
    walk_grant[XING_WEST] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      cmp("hs_hold_req", {7'd0, request_out[XING_WEST]}, 8'h01);
    end
    walk_grant[XING_WEST] = 1'b0;
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      tick(1);
      if (e == 0) cmp("hs_release_req", {7'd0, request_out[XING_WEST]}, 8'h00);
      pulses += int'(walk_served[XING_WEST]);
    end
    cmp("hs_served_pulses", 8'(pulses), 8'h01);

    // Stuck button on north_one: no re-request until released.
    button_raw[XING_NORTH_ONE] = 1'b1;
    tick(DB + 3);
    walk_grant[XING_NORTH_ONE] = 1'b1;
    tick(3);
    walk_grant[XING_NORTH_ONE] = 1'b0;
    for (int e = 0; e < 20 + CD; e++) begin
      tick(1);
      cmp("stuck_no_rereq", {7'd0, request_out[XING_NORTH_ONE]}, 8'h00);
    end
    button_raw[XING_NORTH_ONE] = 1'b0;
    tick(CD + 4);
    button_raw[XING_NORTH_ONE] = 1'b1;
    for (int e = 0; e < DB + 3; e++) begin
      tick(1);
      cmp("stuck_repress", {7'd0, request_out[XING_NORTH_ONE]}, 8'(e >= DB + 2));
    end
    button_raw[XING_NORTH_ONE] = 1'b0;

    // Overdue on south: rises after WAIT_LIMIT pending edges, grant clears it.
    button_raw[XING_SOUTH] = 1'b1;
    for (int e = 0; e <= DB + 2 + WL; e++) begin
      tick(1);
      if (e == 10) button_raw[XING_SOUTH] = 1'b0;
      if (e == DB + 1 + WL) cmp("overdue_before", {7'd0, overdue[XING_SOUTH]}, 8'h00);
      if (e == DB + 2 + WL) cmp("overdue_at_limit", {7'd0, overdue[XING_SOUTH]}, 8'h01);
    end
    walk_grant[XING_SOUTH] = 1'b1;
    tick(1);
    cmp("overdue_cleared", {7'd0, overdue[XING_SOUTH]}, 8'h00);
    walk_grant[XING_SOUTH] = 1'b0;

    // Spurious grant on idle south_one sets a sticky error.
    walk_grant[XING_SOUTH_ONE] = 1'b1;
    tick(1);
    walk_grant[XING_SOUTH_ONE] = 1'b0;
    cmp("grant_error_set", {7'd0, grant_error[XING_SOUTH_ONE]}, 8'h01);
    tick(20);
    cmp("grant_error_sticky", {7'd0, grant_error[XING_SOUTH_ONE]}, 8'h01);

    // All eight at once, then reset mid-pending.
    do_reset();
    button_raw = '1;
    tick(DB + 4);
    cmp("all_pending_count", {4'd0, pending_count}, 8'd8);
    cmp("all_east_one", {7'd0, request_out[XING_EAST_ONE]}, 8'h01);
    cmp("all_west_one", {7'd0, request_out[XING_WEST_ONE]}, 8'h01);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    cmp("rst_request_out", request_out, 8'h00);
    cmp("rst_walk_served", walk_served, 8'h00);
    cmp("rst_overdue", overdue, 8'h00);
    cmp("rst_grant_error", grant_error, 8'h00);
    cmp("rst_pending_count", {4'd0, pending_count}, 8'h00);
    @(posedge clock);
    #2 reset_n = 1'b1;
    button_raw = '0;

    // Random traffic with a controller that grants model-pending channels.
    for (int i = 0; i < N; i++) g_hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) button_raw[i] = ~button_raw[i];
        if (walk_grant[i]) begin
          if (g_hold[i] == 0) walk_grant[i] = 1'b0;
          else g_hold[i]--;
        end else if (m_mode[i] == MWaiting && $urandom_range(0, 5) == 0) begin
          walk_grant[i] = 1'b1;
          g_hold[i]     = int'($urandom_range(0, 6));
        end else if ($urandom_range(0, 299) == 0) begin
          walk_grant[i] = 1'b1;
          g_hold[i]     = 0;
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        walk_grant = '0;
        do_reset();
      end else begin
        tick(1);
      end
    end

    walk_grant = '0;
    button_raw = '0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
